imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction-fetch path. It receives a program as a byte stream over a valid/ready handshake and packs the bytes into little-endian 32-bit words.
- It drives the instruction-memory write port, which the fetch unit then reads.
- It holds the core until a complete, valid image has been written, then releases it. It sits beside the fetch stage in the top level.

Parameters:
- ADDR_W, 8, word-address width of instruction memory.
- DEPTH, 256, number of instruction words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  level-sampled request to begin a load; honoured only in IDLE or DONE.
- word_count  input  ADDR_W+1  number of words to load; sampled on the accepted start.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  program byte, LSB-first within each word.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  assembled instruction word.
- core_hold  output  1  holds fetch/PC and register writes while 1.
- busy  output  1  high in LOAD and WRITE.
- done  output  1  sticky; high in DONE.
- error  output  1  sticky; bad word_count on the last start.

Behaviour:
- Reset (async, reset=0): state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, busy=0, done=0, error=0.
  - Internal byte index, word index, count and shift register all clear to 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE with start=1:
  - If word_count==0 or word_count>DEPTH: error=1, done=0, go to IDLE, core_hold=1.
  - Else: latch count, clear indices, error=0, done=0, go to LOAD.
- LOAD:
  - byte_ready=1.
  - A byte transfers only when byte_valid&&byte_ready. Byte k (k=0..3) goes into shift bits [8k+7:8k].
  - On the 4th transfer, go to WRITE next cycle.
  - Bytes with byte_valid=0 are stalls; state is held indefinitely.
- WRITE, exactly one cycle:
  - imem_we=1, imem_addr=word index, imem_wdata=assembled word, byte_ready=0.
  - If word index==count-1: go to DONE. Else increment word index, clear byte index, return to LOAD.
- DONE:
  - done=1, core_hold=0, byte_ready=0.
  - A new start restarts with the same validation as IDLE; core_hold rises the cycle after start is accepted.
- Latency: 4 accepted bytes to imem_we is 1 cycle. Minimum 5 cycles per word with back-to-back bytes.
- Outside WRITE: imem_we=0; imem_addr and imem_wdata hold their last values.
- core_hold=1 in IDLE, LOAD and WRITE. It is never 0 until a load completes.
- start during LOAD/WRITE is ignored.
- Bytes presented outside LOAD are not consumed (byte_ready=0).
- Address never wraps: validation guarantees the last address is count-1 ≤ DEPTH-1. word_count==DEPTH is legal and writes address DEPTH-1 last.
- Reset mid-operation:
  - The partial word is discarded, with no write.
  - An in-flight imem_we is dropped asynchronously.
  - done/error clear; core_hold returns to 1.
- Memory contents already written are not cleared by this block.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, DONE=2'd3) and the instruction width constant (32).
- One natural sub-module, byte_packer: byte index counter plus shift register. It has a consume-enable input, a 4-byte word_ready output and a clear input.
- The FSM, word counter and validation stay in imem_loader.

Test Plan:
- Basic load: reset release, word_count=2, start, bytes 13,00,50,00, 93,00,10,00 back-to-back.
  - Required: imem_we pulses twice, at addr 0 with wdata 0x00500013 and at addr 1 with wdata 0x00100093.
  - Then done=1, core_hold=0, 10 cycles after the first byte.
- Stalled stream: word_count=1, byte_valid toggled 1/0 with random gaps.
  - Required: exactly one write of the correct word.
  - Between the 4th transfer and the write: no byte_ready and no imem_we.
- Illegal count: word_count=0, then word_count=DEPTH+1 (257).
  - Required: error=1, done=0, core_hold=1, busy=0, no imem_we, byte_ready stays 0.
- Full depth: word_count=256, incrementing word pattern.
  - Required: 256 writes, addr 0..255 in order, last addr 255, no wrap, done=1.
- Reset mid-word: 2 bytes accepted, then reset=0 for one cycle.
  - Required: immediate IDLE outputs, no imem_we.
  - A fresh start with 4 new bytes writes addr 0 with only the new bytes.
- Reload from DONE: after a completed load, start with word_count=1.
  - Required: core_hold=1 next cycle, done=0, new word written at addr 0, then done=1 and core_hold=0 again.
  - A start asserted during LOAD has no effect.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the instruction word width.
package imem_loader_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned BYTES_PER_WORD = INSTR_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an LSB-first byte stream into 32-bit words. word_next is the value
// the shift register takes this cycle, so the caller can capture a complete
// word in the same cycle the fourth byte is consumed.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               consume,
  input  logic [7:0]         byte_data,
  output logic [INSTR_W-1:0] word_next,
  output logic               word_ready
);

  logic [1:0]         idx;
  logic [INSTR_W-1:0] shift;

  // Insert the incoming byte into its lane of the current word.
  always_comb begin
    word_next = shift;
    if (consume) begin
      case (idx)
        2'd0: word_next[7:0]   = byte_data;
        2'd1: word_next[15:8]  = byte_data;
        2'd2: word_next[23:16] = byte_data;
        2'd3: word_next[31:24] = byte_data;
        default: word_next = shift;
      endcase
    end
  end

  assign word_ready = consume && (idx == 2'd3);

  // Byte index and shift register; the index wraps to 0 after the 4th byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      shift <= '0;
    end else if (clear) begin
      idx   <= '0;
      shift <= '0;
    end else if (consume) begin
      idx   <= idx + 2'd1;
      shift <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a program byte stream, writes packed
// words to instruction memory and holds the core until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    word_count,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W-1:0]   word_idx;
  logic [ADDR_W:0]     count;
  logic                consume;
  logic                start_ok;
  logic                count_bad;
  logic                last_word;
  logic                word_ready;
  logic [INSTR_W-1:0]  word_next;

  assign consume   = byte_valid && byte_ready;
  assign count_bad = (word_count == '0) || (word_count > DEPTH_W);
  assign start_ok  = start && !count_bad && ((state == IDLE) || (state == DONE));
  assign last_word = ({1'b0, word_idx} == (count - ONE_W));

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .consume    (consume),
    .byte_data  (byte_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  // Load FSM with registered handshake, memory-port and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      word_idx   <= '0;
      count      <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done       <= 1'b0;
            core_hold  <= 1'b1;
            if (count_bad) begin
              error      <= 1'b1;
              state      <= IDLE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
            end else begin
              error      <= 1'b0;
              count      <= word_count;
              word_idx   <= '0;
              state      <= LOAD;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_ready) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= word_idx;
            imem_wdata <= word_next;
          end
        end
        WRITE: begin
          if (last_word) begin
            state     <= DONE;
            done      <= 1'b1;
            core_hold <= 1'b0;
            busy      <= 1'b0;
          end else begin
            word_idx   <= word_idx + 1'b1;
            state      <= LOAD;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
